// File: rtl/util_axis_keep_width_converter.sv
// AXI-Stream byte-width converter (upsize / downsize / equal) carrying tkeep and tlast.
// Optional null-beat skipping in downsize mode: UTIL_AXIS_KEEP_WIDTH_CONVERTER_NULL_SKIP_EN.
module util_axis_keep_width_converter #(
    parameter int MASTER_WIDTH = 2,
    parameter int SLAVE_WIDTH  = 16
) (
    input  logic                      aclk,
    input  logic                      arst,
    input  logic [SLAVE_WIDTH*8-1:0]  s_axis_tdata,
    input  logic [SLAVE_WIDTH-1:0]    s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [MASTER_WIDTH*8-1:0] m_axis_tdata,
    output logic [MASTER_WIDTH-1:0]   m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready
);

    localparam int MAX_W = (MASTER_WIDTH > SLAVE_WIDTH) ? MASTER_WIDTH : SLAVE_WIDTH;
    localparam int MIN_W = (MASTER_WIDTH > SLAVE_WIDTH) ? SLAVE_WIDTH : MASTER_WIDTH;
    localparam int RATIO = MAX_W / MIN_W;
    localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int MDW   = MASTER_WIDTH * 8;
    localparam int SDW   = SLAVE_WIDTH * 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    if ((MAX_W % MIN_W) != 0) begin : g_bad_ratio
        $error("util_axis_keep_width_converter: widths must have an integer ratio");
    end

    // Holds s_axis_tready low until the first edge after reset release.
    logic rdy_en;
    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    if (MASTER_WIDTH == SLAVE_WIDTH) begin : g_equal
        logic [MDW-1:0]          q_data;
        logic [MASTER_WIDTH-1:0] q_keep;
        logic                    q_last;
        logic                    q_valid;
        logic                    s_ready;

        assign s_ready = rdy_en && (!q_valid || m_axis_tready);

        always_ff @(posedge aclk or posedge arst) begin
            if (arst) begin
                q_data  <= '0;
                q_keep  <= '0;
                q_last  <= 1'b0;
                q_valid <= 1'b0;
            end else if (s_axis_tvalid && s_ready) begin
                q_data  <= s_axis_tdata;
                q_keep  <= s_axis_tkeep;
                q_last  <= s_axis_tlast;
                q_valid <= 1'b1;
            end else if (m_axis_tready) begin
                q_valid <= 1'b0;
            end
        end

        assign s_axis_tready = s_ready;
        assign m_axis_tdata  = q_data;
        assign m_axis_tkeep  = q_keep;
        assign m_axis_tlast  = q_last;
        assign m_axis_tvalid = q_valid;

    end else if (MASTER_WIDTH > SLAVE_WIDTH) begin : g_up
        logic [MDW-1:0]          acc_data;
        logic [MDW-1:0]          acc_data_wr;
        logic [MASTER_WIDTH-1:0] acc_keep;
        logic [MASTER_WIDTH-1:0] acc_keep_wr;
        logic [CW-1:0]           cnt;
        logic [MDW-1:0]          q_data;
        logic [MASTER_WIDTH-1:0] q_keep;
        logic                    q_last;
        logic                    q_valid;
        logic                    s_ready;
        logic                    s_fire;
        logic                    flush;

        assign s_ready = rdy_en && (!q_valid || m_axis_tready);
        assign s_fire  = s_axis_tvalid && s_ready;
        assign flush   = s_axis_tlast || (cnt == CW'(RATIO - 1));

        // Lanes above cnt are always zero because the accumulator clears on every flush.
        always_comb begin
            acc_data_wr = acc_data;
            acc_keep_wr = acc_keep;
            for (int i = 0; i < RATIO; i++) begin
                if (cnt == CW'(i)) begin
                    acc_data_wr[i*SDW +: SDW]                 = s_axis_tdata;
                    acc_keep_wr[i*SLAVE_WIDTH +: SLAVE_WIDTH] = s_axis_tkeep;
                end
            end
        end

        always_ff @(posedge aclk or posedge arst) begin
            if (arst) begin
                acc_data <= '0;
                acc_keep <= '0;
                cnt      <= '0;
                q_data   <= '0;
                q_keep   <= '0;
                q_last   <= 1'b0;
                q_valid  <= 1'b0;
            end else begin
                if (m_axis_tready) begin
                    q_valid <= 1'b0;
                end
                if (s_fire) begin
                    if (flush) begin
                        q_data   <= acc_data_wr;
                        q_keep   <= acc_keep_wr;
                        q_last   <= s_axis_tlast;
                        q_valid  <= 1'b1;
                        acc_data <= '0;
                        acc_keep <= '0;
                        cnt      <= '0;
                    end else begin
                        acc_data <= acc_data_wr;
                        acc_keep <= acc_keep_wr;
                        cnt      <= cnt + CW'(1);
                    end
                end
            end
        end

        assign s_axis_tready = s_ready;
        assign m_axis_tdata  = q_data;
        assign m_axis_tkeep  = q_keep;
        assign m_axis_tlast  = q_last;
        assign m_axis_tvalid = q_valid;

    end else begin : g_down
        state_t                 state;
        state_t                 state_nxt;
        logic [CW-1:0]          idx;
        logic [CW-1:0]          idx_nxt;
        logic [CW-1:0]          last_idx;
        logic [SDW-1:0]         buf_data;
        logic [SLAVE_WIDTH-1:0] buf_keep;
        logic                   buf_last;
        logic                   load;
        logic                   at_end;
        logic                   s_ready;
        logic                   s_fire;
        logic [MDW-1:0]         m_data;
        logic [MASTER_WIDTH-1:0] m_keep;

`ifdef UTIL_AXIS_KEEP_WIDTH_CONVERTER_NULL_SKIP_EN
        // A tlast word ends on its highest non-null beat; an all-null tlast word ends on beat 0.
        logic [CW-1:0] nz_idx;
        always_comb begin
            nz_idx = '0;
            for (int i = 0; i < RATIO; i++) begin
                if (|buf_keep[i*MASTER_WIDTH +: MASTER_WIDTH]) begin
                    nz_idx = CW'(i);
                end
            end
        end
        assign last_idx = buf_last ? nz_idx : CW'(RATIO - 1);
`else
        assign last_idx = CW'(RATIO - 1);
`endif

        assign at_end  = (idx == last_idx);
        assign s_ready = rdy_en && ((state == ST_IDLE) || (at_end && m_axis_tready));
        assign s_fire  = s_axis_tvalid && s_ready;

        always_ff @(posedge aclk or posedge arst) begin
            if (arst) begin
                state <= ST_IDLE;
                idx   <= '0;
            end else begin
                state <= state_nxt;
                idx   <= idx_nxt;
            end
        end

        always_comb begin
            state_nxt = state;
            idx_nxt   = idx;
            load      = 1'b0;
            case (state)
                ST_IDLE: begin
                    if (s_fire) begin
                        load      = 1'b1;
                        state_nxt = ST_SEND;
                        idx_nxt   = '0;
                    end
                end
                ST_SEND: begin
                    if (m_axis_tready) begin
                        if (at_end) begin
                            idx_nxt = '0;
                            if (s_fire) begin
                                load = 1'b1;
                            end else begin
                                state_nxt = ST_IDLE;
                            end
                        end else begin
                            idx_nxt = idx + CW'(1);
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    idx_nxt   = '0;
                end
            endcase
        end

        always_ff @(posedge aclk or posedge arst) begin
            if (arst) begin
                buf_data <= '0;
                buf_keep <= '0;
                buf_last <= 1'b0;
            end else if (load) begin
                buf_data <= s_axis_tdata;
                buf_keep <= s_axis_tkeep;
                buf_last <= s_axis_tlast;
            end
        end

        always_comb begin
            m_data = '0;
            m_keep = '0;
            for (int i = 0; i < RATIO; i++) begin
                if (idx == CW'(i)) begin
                    m_data = buf_data[i*MDW +: MDW];
                    m_keep = buf_keep[i*MASTER_WIDTH +: MASTER_WIDTH];
                end
            end
        end

        assign s_axis_tready = s_ready;
        assign m_axis_tdata  = m_data;
        assign m_axis_tkeep  = m_keep;
        assign m_axis_tlast  = (state == ST_SEND) && buf_last && at_end;
        assign m_axis_tvalid = (state == ST_SEND);
    end

endmodule

// File: tb/tb_util_axis_keep_width_converter.sv
// Bench for util_axis_keep_width_converter: 16->2 downsize, 2->16 upsize and 4->4 pass-through instances.
module tb_util_axis_keep_width_converter;

    logic clk = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // downsize 16 -> 2
    logic [127:0] dn_s_data;
    logic [15:0]  dn_s_keep;
    logic         dn_s_last, dn_s_valid, dn_s_ready;
    logic [15:0]  dn_m_data;
    logic [1:0]   dn_m_keep;
    logic         dn_m_last, dn_m_valid, dn_m_ready;
    // upsize 2 -> 16
    logic [15:0]  up_s_data;
    logic [1:0]   up_s_keep;
    logic         up_s_last, up_s_valid, up_s_ready;
    logic [127:0] up_m_data;
    logic [15:0]  up_m_keep;
    logic         up_m_last, up_m_valid, up_m_ready;
    // equal 4 -> 4
    logic [31:0]  eq_s_data;
    logic [3:0]   eq_s_keep;
    logic         eq_s_last, eq_s_valid, eq_s_ready;
    logic [31:0]  eq_m_data;
    logic [3:0]   eq_m_keep;
    logic         eq_m_last, eq_m_valid, eq_m_ready;

    util_axis_keep_width_converter #(.MASTER_WIDTH(2), .SLAVE_WIDTH(16)) dut_dn (
        .aclk(clk), .arst(arst),
        .s_axis_tdata(dn_s_data), .s_axis_tkeep(dn_s_keep), .s_axis_tlast(dn_s_last),
        .s_axis_tvalid(dn_s_valid), .s_axis_tready(dn_s_ready),
        .m_axis_tdata(dn_m_data), .m_axis_tkeep(dn_m_keep), .m_axis_tlast(dn_m_last),
        .m_axis_tvalid(dn_m_valid), .m_axis_tready(dn_m_ready));

    util_axis_keep_width_converter #(.MASTER_WIDTH(16), .SLAVE_WIDTH(2)) dut_up (
        .aclk(clk), .arst(arst),
        .s_axis_tdata(up_s_data), .s_axis_tkeep(up_s_keep), .s_axis_tlast(up_s_last),
        .s_axis_tvalid(up_s_valid), .s_axis_tready(up_s_ready),
        .m_axis_tdata(up_m_data), .m_axis_tkeep(up_m_keep), .m_axis_tlast(up_m_last),
        .m_axis_tvalid(up_m_valid), .m_axis_tready(up_m_ready));

    util_axis_keep_width_converter #(.MASTER_WIDTH(4), .SLAVE_WIDTH(4)) dut_eq (
        .aclk(clk), .arst(arst),
        .s_axis_tdata(eq_s_data), .s_axis_tkeep(eq_s_keep), .s_axis_tlast(eq_s_last),
        .s_axis_tvalid(eq_s_valid), .s_axis_tready(eq_s_ready),
        .m_axis_tdata(eq_m_data), .m_axis_tkeep(eq_m_keep), .m_axis_tlast(eq_m_last),
        .m_axis_tvalid(eq_m_valid), .m_axis_tready(eq_m_ready));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one record per clock for the downsize streaming vectors
    typedef struct {
        logic         s_valid;
        logic [127:0] s_data;
        logic         s_last;
        logic         m_ready;
        logic         e_valid;
        logic [15:0]  e_data;
        logic [1:0]   e_keep;
        logic         e_last;
        logic         e_sready;
    } dvec_t;

    typedef struct packed {
        logic [127:0] d;
        logic [15:0]  k;
        logic         l;
    } beat_t;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } eb_t;

    function automatic dvec_t dv(input logic sv, input logic [127:0] sd, input logic sl,
                                 input logic mr, input logic ev, input logic [15:0] ed,
                                 input logic [1:0] ek, input logic el, input logic es);
        dvec_t r;
        r.s_valid = sv; r.s_data = sd; r.s_last = sl; r.m_ready = mr;
        r.e_valid = ev; r.e_data = ed; r.e_keep = ek; r.e_last = el; r.e_sready = es;
        return r;
    endfunction

    logic [127:0] dw_data [3];
    logic [15:0]  dw_keep [3];
    logic         dw_last [3];

    // drives dw_* words into the downsizer and checks beats against a byte-slice model
    task automatic down_run(input int nw, input bit rnd);
        beat_t       q[$];
        int          wi = 0;
        int          got = 0;
        int          lastb;
        logic        pv = 1'b0;
        logic        pr = 1'b1;
        logic [15:0] pd = '0;
        for (int w = 0; w < nw; w++) begin
            lastb = 7;
`ifdef UTIL_AXIS_KEEP_WIDTH_CONVERTER_NULL_SKIP_EN
            if (dw_last[w]) begin
                lastb = 0;
                for (int i = 0; i < 8; i++) if (|dw_keep[w][i*2 +: 2]) lastb = i;
            end
`endif
            for (int i = 0; i <= lastb; i++)
                q.push_back('{d: 128'(dw_data[w][i*16 +: 16]), k: 16'(dw_keep[w][i*2 +: 2]),
                              l: dw_last[w] && (i == lastb)});
        end
        for (int c = 0; c < 400 && got < q.size(); c++) begin
            dn_s_valid = (wi < nw);
            if (wi < nw) begin
                dn_s_data = dw_data[wi];
                dn_s_keep = dw_keep[wi];
                dn_s_last = dw_last[wi];
            end
            dn_m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (pv && !pr) begin
                chk("dn_hold_valid", 128'(dn_m_valid), 128'(1));
                chk("dn_hold_data", 128'(dn_m_data), 128'(pd));
            end
            if (dn_m_valid && dn_m_ready) begin
                chk("dn_seq_data", 128'(dn_m_data), q[got].d);
                chk("dn_seq_keep", 128'(dn_m_keep), 128'(q[got].k));
                chk("dn_seq_last", 128'(dn_m_last), 128'(q[got].l));
                got++;
            end
            if (dn_s_valid && dn_s_ready) wi++;
            pv = dn_m_valid; pr = dn_m_ready; pd = dn_m_data;
            @(posedge clk); #1;
        end
        dn_s_valid = 1'b0;
        dn_m_ready = 1'b1;
        chk("dn_beat_count", 128'(got), 128'(q.size()));
        #1;
        chk("dn_drained", 128'(dn_m_valid), 128'(0));
        @(posedge clk); #1;
    endtask

    // presents one upsizer input beat and returns one cycle after it is accepted
    task automatic up_beat(input logic [15:0] d, input logic [1:0] k, input logic l);
        int n = 0;
        up_s_valid = 1'b1; up_s_data = d; up_s_keep = k; up_s_last = l;
        #1;
        while (!up_s_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 20) chk("up_ready_timeout", 128'(up_s_ready), 128'(1));
        @(posedge clk); #1;
        up_s_valid = 1'b0;
    endtask

    dvec_t        dtab[$];
    logic [127:0] w0, w1;
    eb_t          eq_q[$];
    eb_t          e;
    int           sent, got;
    bit           acc;
    logic [127:0] held;

    initial begin
        dn_s_data = '0; dn_s_keep = '0; dn_s_last = 0; dn_s_valid = 0; dn_m_ready = 1;
        up_s_data = '0; up_s_keep = '0; up_s_last = 0; up_s_valid = 0; up_m_ready = 1;
        eq_s_data = '0; eq_s_keep = '0; eq_s_last = 0; eq_s_valid = 0; eq_m_ready = 1;

        // downsize vectors: word of 5500 lanes, then 5601 lanes with tlast and one stall
        w0 = {8{16'h5500}};
        w1 = {8{16'h5601}};
        dtab.push_back(dv(1, w0, 0, 1, 0, 16'h0, 2'b00, 0, 1));
        for (int b = 0; b < 8; b++)
            dtab.push_back(dv(1, w1, 1, 1, 1, 16'h5500, 2'b11, 0, b == 7));
        for (int b = 0; b < 8; b++) begin
            if (b == 3) dtab.push_back(dv(0, w1, 1, 0, 1, 16'h5601, 2'b11, 0, 0));
            dtab.push_back(dv(0, w1, 1, 1, 1, 16'h5601, 2'b11, b == 7, b == 7));
        end
        dtab.push_back(dv(0, w1, 0, 1, 0, 16'h0, 2'b00, 0, 1));

        // reset
        #500;
        chk("rst_dn_sready", 128'(dn_s_ready), 128'(0));
        chk("rst_dn_mvalid", 128'(dn_m_valid), 128'(0));
        chk("rst_dn_mout", {dn_m_data, dn_m_keep, dn_m_last}, 128'(0));
        chk("rst_up_sready", 128'(up_s_ready), 128'(0));
        chk("rst_up_mout", {up_m_data[108:0], up_m_keep, up_m_last, up_m_valid, up_m_data[127:109] != 0}, 128'(0));
        chk("rst_eq_sready", 128'(eq_s_ready), 128'(0));
        chk("rst_eq_mout", {eq_m_data, eq_m_keep, eq_m_last, eq_m_valid}, 128'(0));
        #500;
        arst = 1'b0;
        #1;
        chk("rel_sready_early", 128'(dn_s_ready), 128'(0));
        @(posedge clk); #1;
        chk("rel_dn_sready", 128'(dn_s_ready), 128'(1));
        chk("rel_up_sready", 128'(up_s_ready), 128'(1));
        chk("rel_eq_sready", 128'(eq_s_ready), 128'(1));

        // downsize table, one record per cycle
        dn_s_keep = 16'hFFFF;
        for (int i = 0; i < dtab.size(); i++) begin
            dn_s_valid = dtab[i].s_valid;
            dn_s_data  = dtab[i].s_data;
            dn_s_last  = dtab[i].s_last;
            dn_m_ready = dtab[i].m_ready;
            #1;
            chk($sformatf("dn_tab%0d_valid", i), 128'(dn_m_valid), 128'(dtab[i].e_valid));
            chk($sformatf("dn_tab%0d_sready", i), 128'(dn_s_ready), 128'(dtab[i].e_sready));
            if (dtab[i].e_valid) begin
                chk($sformatf("dn_tab%0d_data", i), 128'(dn_m_data), 128'(dtab[i].e_data));
                chk($sformatf("dn_tab%0d_keep", i), 128'(dn_m_keep), 128'(dtab[i].e_keep));
                chk($sformatf("dn_tab%0d_last", i), 128'(dn_m_last), 128'(dtab[i].e_last));
            end
            @(posedge clk); #1;
        end
        dn_s_valid = 1'b0;

        // downsize with random output ready
        dw_data[0] = 128'h0f0e0d0c0b0a09080706050403020100; dw_keep[0] = 16'hFFFF; dw_last[0] = 1;
        dw_data[1] = 128'h100f0e0d0c0b0a090807060504030201; dw_keep[1] = 16'hA5C3; dw_last[1] = 1;
        dw_data[2] = 128'h11121314151617181920212223242526; dw_keep[2] = 16'hFFFF; dw_last[2] = 0;
        down_run(3, 1);

        // partial-keep tlast words (null-skip behaviour depends on build)
        dw_data[0] = 128'h11112222333344445555666677778888; dw_keep[0] = 16'h000F; dw_last[0] = 0;
        dw_data[1] = 128'h11112222333344445555666677778888; dw_keep[1] = 16'h000F; dw_last[1] = 1;
        dw_data[2] = 128'h99990000aaaabbbbccccddddeeeeffff; dw_keep[2] = 16'h0000; dw_last[2] = 1;
        down_run(3, 0);

        // upsize: short packet, full word, stall, single-beat packet, null lane
        up_m_ready = 1'b1;
        up_beat(16'h0102, 2'b11, 0);
        chk("up_partial_v1", 128'(up_m_valid), 128'(0));
        up_beat(16'h0304, 2'b11, 0);
        chk("up_partial_v2", 128'(up_m_valid), 128'(0));
        up_beat(16'h0506, 2'b11, 1);
        chk("up_short_valid", 128'(up_m_valid), 128'(1));
        chk("up_short_data", up_m_data, 128'h0000_0000_0000_0000_0000_0506_0304_0102);
        chk("up_short_keep", 128'(up_m_keep), 128'h003F);
        chk("up_short_last", 128'(up_m_last), 128'(1));
        for (int i = 0; i < 8; i++) begin
            up_beat(16'h1000 + 16'(i), 2'b11, 0);
            if (i == 0) chk("up_prev_consumed", 128'(up_m_valid), 128'(0));
        end
        chk("up_full_valid", 128'(up_m_valid), 128'(1));
        chk("up_full_data", up_m_data, 128'h1007_1006_1005_1004_1003_1002_1001_1000);
        chk("up_full_keep", 128'(up_m_keep), 128'hFFFF);
        chk("up_full_last", 128'(up_m_last), 128'(0));
        up_m_ready = 1'b0;
        held = up_m_data;
        #1;
        chk("up_stall_sready", 128'(up_s_ready), 128'(0));
        @(posedge clk); #1;
        chk("up_stall_valid", 128'(up_m_valid), 128'(1));
        chk("up_stall_data", up_m_data, held);
        up_m_ready = 1'b1;
        up_beat(16'hABCD, 2'b01, 1);
        chk("up_one_valid", 128'(up_m_valid), 128'(1));
        chk("up_one_data", up_m_data, 128'h0000_ABCD);
        chk("up_one_keep", 128'(up_m_keep), 128'h0001);
        chk("up_one_last", 128'(up_m_last), 128'(1));
        up_beat(16'h7777, 2'b00, 0);
        up_beat(16'h8888, 2'b11, 1);
        chk("up_null_data", up_m_data, 128'h8888_7777);
        chk("up_null_keep", 128'(up_m_keep), 128'h000C);
        chk("up_null_last", 128'(up_m_last), 128'(1));
        @(posedge clk); #1;

        // equal width: single-cycle latency, then random traffic
        eq_m_ready = 1'b1;
        eq_s_valid = 1'b1; eq_s_data = 32'hDEADBEEF; eq_s_keep = 4'hA; eq_s_last = 1'b1;
        #1;
        chk("eq_lat_sready", 128'(eq_s_ready), 128'(1));
        @(posedge clk); #1;
        eq_s_valid = 1'b0;
        chk("eq_lat_valid", 128'(eq_m_valid), 128'(1));
        chk("eq_lat_data", 128'(eq_m_data), 128'hDEADBEEF);
        chk("eq_lat_keep", 128'(eq_m_keep), 128'hA);
        chk("eq_lat_last", 128'(eq_m_last), 128'(1));
        @(posedge clk); #1;
        chk("eq_lat_done", 128'(eq_m_valid), 128'(0));

        sent = 0; got = 0;
        for (int c = 0; c < 3000 && (sent < 100 || got < sent); c++) begin
            if (!eq_s_valid && sent < 100 && $urandom_range(0, 2) != 0) begin
                eq_s_valid = 1'b1;
                eq_s_data  = $urandom;
                eq_s_keep  = 4'($urandom);
                eq_s_last  = 1'($urandom);
            end
            eq_m_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (eq_m_valid && eq_m_ready) begin
                if (eq_q.size() == 0) begin
                    chk("eq_spurious", 128'(eq_m_valid), 128'(0));
                end else begin
                    e = eq_q.pop_front();
                    chk("eq_seq_data", 128'(eq_m_data), 128'(e.d));
                    chk("eq_seq_keep", 128'(eq_m_keep), 128'(e.k));
                    chk("eq_seq_last", 128'(eq_m_last), 128'(e.l));
                    got++;
                end
            end
            acc = eq_s_valid && eq_s_ready;
            if (acc) begin
                eq_q.push_back('{d: eq_s_data, k: eq_s_keep, l: eq_s_last});
                sent++;
            end
            @(posedge clk); #1;
            if (acc) eq_s_valid = 1'b0;
        end
        eq_s_valid = 1'b0;
        eq_m_ready = 1'b1;
        chk("eq_count", 128'(got), 128'(100));

        // reset in the middle of a downsized packet
        dn_m_ready = 1'b1;
        dn_s_valid = 1'b1; dn_s_data = 128'h0123456789abcdef0123456789abcdef;
        dn_s_keep = 16'hFFFF; dn_s_last = 1'b1;
        @(posedge clk); #1;
        dn_s_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mid_valid_before", 128'(dn_m_valid), 128'(1));
        #2 arst = 1'b1;
        #1;
        chk("mid_valid_drop", 128'(dn_m_valid), 128'(0));
        chk("mid_sready_drop", 128'(dn_s_ready), 128'(0));
        chk("mid_out_clear", {dn_m_data, dn_m_keep, dn_m_last}, 128'(0));
        @(negedge clk);
        arst = 1'b0;
        #1;
        chk("mid_sready_hold", 128'(dn_s_ready), 128'(0));
        @(posedge clk); #1;
        chk("mid_sready_back", 128'(dn_s_ready), 128'(1));
        chk("mid_idle", 128'(dn_m_valid), 128'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
